requant_output_packer: RTL
==========================

# requant_output_packer

Downstream stage of the requantize/activation unit. Accepts the 8-bit activation results one byte per handshake, packs them little-endian into 32-bit words, buffers the words in a small FIFO and writes them to the output feature-map SRAM at consecutive word addresses. It handles a partial final word with byte strobes and signals completion of a job of programmable length.

## Interface
Parameters:
- FIFO_DEPTH, 4: packed-word FIFO entries; power of 2, ≥2.
- ADDR_W, 16: SRAM word-address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on start.
- num_bytes  in  16  job length in bytes; latched on start.
- in_valid  in  1  result byte valid.
- in_data  in  8  result byte from requantize stage.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- mem_wr_en  out  1  write request; held until accepted.
- mem_addr  out  ADDR_W  word address of request.
- mem_wdata  out  32  packed word.
- mem_wstrb  out  4  byte enables; bit k covers mem_wdata[8k+7:8k].
- mem_ready  in  1  write accepted when mem_wr_en && mem_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch base_addr and num_bytes, clear byte counter, lane index and pack register. Go to RUN, or to DONE if num_bytes == 0.
- RUN: in_ready = !fifo_full && (bytes_accepted < num_bytes). Each accepted byte goes to lane = bytes_accepted[1:0]; bytes_accepted increments.
- Word push: on the cycle the lane-3 byte is accepted, or the final byte (bytes_accepted+1 == num_bytes) is accepted, push {word, strb} into the FIFO and clear the pack register and strobes.
  - The word includes the byte accepted that cycle.
  - strb = lanes written so far, e.g. 3 bytes gives 4'b0111.
  - Unwritten lanes carry 0.
- After the final push: RUN → DRAIN.
- Write side, active in RUN and DRAIN:
  - mem_wr_en = !fifo_empty, with mem_wdata/mem_wstrb from the FIFO head.
  - mem_addr = base + words_written, wrapping modulo 2^ADDR_W.
  - On mem_wr_en && mem_ready: pop, and words_written increments.
  - Request stays stable while mem_ready is low.
- DRAIN: when the last FIFO entry is accepted → DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. in_valid outside RUN, or beyond num_bytes, is ignored (in_ready = 0).
- Push and pop in the same cycle are legal; occupancy is unchanged.
- FIFO full: in_ready is low from that cycle onward. No byte is lost or overwritten.

## Timing
- Reset values: in_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0. FIFO, counters and pack register are cleared. State = IDLE.
- Reset asserted mid-job: job is abandoned. No further writes start on the cycle after rst. A pending write is dropped.
- start in cycle T: busy=1 and in_ready may be 1 at T+1.
- The word pushed in cycle T appears as mem_wr_en=1 at T+1 at the earliest (registered FIFO).
- With mem_ready tied high and in_valid continuous: sustained 1 byte/cycle, one write per 4 bytes, no in_ready stalls.
- done is asserted the cycle after the final write handshake. busy falls the cycle after done.
- num_bytes=0: start at T gives done=1 at T+1, busy=0 at T+2, and no writes.

## Test plan
- Full words: base=0x0010, num_bytes=8, bytes 0x01..0x08, mem_ready=1 → writes (0x0010, 0x04030201, 4'b1111) and (0x0011, 0x08070605, 4'b1111); done one cycle after the second write; busy low the cycle after.
- Partial tail: num_bytes=6, bytes 0xA0..0xA5 → second write data 0x0000A5A4, strb 4'b0011; exactly 2 writes.
- Backpressure: num_bytes=24, mem_ready=0 → FIFO fills after 16 bytes and in_ready drops. Then release mem_ready → 6 writes in order, addresses consecutive, no byte lost; mem_addr/mem_wdata are stable while stalled.
- Zero length, and start ignored while busy: num_bytes=0 → done at T+1 with no mem_wr_en. A second start pulsed mid-job with a different base_addr has no effect on addresses.
- Address wrap: ADDR_W=16, base=0xFFFF, num_bytes=8 → writes to 0xFFFF then 0x0000.
- Reset mid-job: rst asserted after 5 of 12 bytes with one write pending → next cycle mem_wr_en=0, busy=0, in_ready=0. A new job with num_bytes=4 then completes normally at its own base_addr.

Source files
------------

// File: rtl/requant_output_packer.sv
// Packs requantized result bytes little-endian into 32-bit words and streams them to the output SRAM.
// A packed word reaches mem_wr_en one cycle after it is pushed; in_ready drops while the word FIFO is full.

module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic             one_left
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    full     = (count == (AW + 1)'(DEPTH));
    empty    = (count == '0);
    one_left = (count == (AW + 1)'(1));
    head_dat = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module requant_output_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_bytes,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] words_written;
  logic [15:0]       len_q;
  logic [15:0]       bytes_accepted;
  logic [31:0]       pack_data;
  logic [3:0]        pack_strb;

  logic        accept;
  logic        push;
  logic        pop;
  logic        last_byte;
  logic [1:0]  lane;
  logic [31:0] word_next;
  logic [3:0]  strb_next;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_one_left;
  logic [35:0] fifo_head;

  always_comb begin
    in_ready  = (state == S_RUN) && !fifo_full && (bytes_accepted < len_q);
    accept    = in_valid && in_ready;
    lane      = bytes_accepted[1:0];
    last_byte = ((bytes_accepted + 16'd1) == len_q);
    word_next = pack_data;
    word_next[{lane, 3'b000} +: 8] = in_data;
    strb_next = pack_strb | (4'b0001 << lane);
    // A word leaves the pack register when lane 3 fills or the job's last byte arrives.
    push      = accept && ((lane == 2'd3) || last_byte);

    mem_wr_en = ((state == S_RUN) || (state == S_DRAIN)) && !fifo_empty;
    mem_wdata = mem_wr_en ? fifo_head[31:0] : 32'd0;
    mem_wstrb = mem_wr_en ? fifo_head[35:32] : 4'd0;
    mem_addr  = base_q + words_written;
    pop       = mem_wr_en && mem_ready;

    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  sync_fifo #(
    .WIDTH(36),
    .DEPTH(FIFO_DEPTH)
  ) u_word_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({strb_next, word_next}),
    .pop      (pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      base_q         <= '0;
      words_written  <= '0;
      len_q          <= '0;
      bytes_accepted <= '0;
      pack_data      <= '0;
      pack_strb      <= '0;
    end else begin
      if (pop) begin
        words_written <= words_written + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= num_bytes;
            bytes_accepted <= '0;
            words_written  <= '0;
            pack_data      <= '0;
            pack_strb      <= '0;
            state          <= (num_bytes == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            bytes_accepted <= bytes_accepted + 16'd1;
            if (push) begin
              pack_data <= '0;
              pack_strb <= '0;
            end else begin
              pack_data <= word_next;
              pack_strb <= strb_next;
            end
            if (push && last_byte) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The final push happened in RUN, so the last pop always lands here.
          if (pop && fifo_one_left) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
